adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader_pkg.sv | 50 +++++
 rtl/spi_clk_div.sv | 30 +++
 rtl/adc_spi_reader.sv | 195 +++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_reader_pkg.sv
// Shared definitions for the ADC SPI frame: FSM states, frame length,
// field widths and bit offsets (also used by the converter-side SPI slave).
package adc_spi_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    localparam int unsigned FRAME_LEN = 136;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned NPLC_W    = 10;
    localparam int unsigned CMD_W     = 16;

    localparam int unsigned PWM_W     = 32;
    localparam int unsigned RUNDOWN_W = 12;
    localparam int unsigned RES8_W    = 8;
    localparam int unsigned ERR_W     = 3;

    // LSB position of each field inside the received frame (bit 0 is pad)
    localparam int unsigned PWM_NB_LSB  = 104;
    localparam int unsigned PWM_PB_LSB  = 72;
    localparam int unsigned PWM_PA_LSB  = 40;
    localparam int unsigned RUNDOWN_LSB = 28;
    localparam int unsigned N64_LSB     = 20;
    localparam int unsigned P8_LSB      = 12;
    localparam int unsigned N1_LSB      = 4;
    localparam int unsigned ERR_LSB     = 1;

    typedef struct packed {
        logic [PWM_W-1:0]     pwm_nb;
        logic [PWM_W-1:0]     pwm_pb;
        logic [PWM_W-1:0]     pwm_pa;
        logic [RUNDOWN_W-1:0] rundown;
        logic [RES8_W-1:0]    n64;
        logic [RES8_W-1:0]    p8;
        logic [RES8_W-1:0]    n1;
        logic [ERR_W-1:0]     err;
    } result_t;

    // Command word placed at the head of the transmitted frame
    function automatic logic [CMD_W-1:0] make_cmd(input logic [NPLC_W-1:0] nplc);
        return CMD_W'(nplc);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: while enabled, tick pulses once every CLKDIV
// clk cycles; disabling restarts the count so each state gets a full period.
module spi_clk_div
    import adc_spi_reader_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKDIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master that sends the integration command to the ADC converter and
// unpacks the returned runup/rundown frame into result registers.
module adc_spi_reader
    import adc_spi_reader_pkg::*;
#(
    parameter int unsigned CLKDIV     = 4,
    parameter int unsigned FRAME_BITS = FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NPLC_W-1:0]    nplc,
    output logic                 sck,
    output logic                 cs,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 busy,
    output logic                 done,
    output logic [PWM_W-1:0]     pwm_nb,
    output logic [PWM_W-1:0]     pwm_pb,
    output logic [PWM_W-1:0]     pwm_pa,
    output logic [RUNDOWN_W-1:0] rundown,
    output logic [RES8_W-1:0]    n64,
    output logic [RES8_W-1:0]    p8,
    output logic [RES8_W-1:0]    n1,
    output logic [ERR_W-1:0]     err_code,
    output logic                 conv_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS);

    state_t                state_q, state_d;
    logic                  sck_q, sck_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tail_q, tail_d;
    logic                  conv_err_q, conv_err_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    result_t               res_q, res_d;
    logic                  div_en;
    logic                  tick;

    assign div_en = (state_q != IDLE);

    spi_clk_div #(
        .CLKDIV(CLKDIV)
    ) u_clk_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tail_q     <= 1'b0;
            conv_err_q <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            bitcnt_q   <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tail_q     <= tail_d;
            conv_err_q <= conv_err_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bitcnt_q   <= bitcnt_d;
            res_q      <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tail_d     = tail_q;
        conv_err_d = conv_err_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bitcnt_d   = bitcnt_q;
        res_d      = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETUP;
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    tx_d     = '0;
                    tx_d[FRAME_BITS-1 -: CMD_W] = make_cmd(nplc);
                    mosi_d   = tx_d[FRAME_BITS-1];
                    rx_d     = '0;
                    bitcnt_d = '0;
                    tail_d   = 1'b0;
                end
            end

            SETUP, SHIFT_LO: begin
                // miso is captured on the same edge that raises sck
                if (tick) begin
                    state_d  = SHIFT_HI;
                    sck_d    = 1'b1;
                    rx_d     = {rx_q[FRAME_BITS-2:0], miso};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end

            SHIFT_HI: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = SHIFT_LO;
                        tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = tx_q[FRAME_BITS-2];
                    end
                end
            end

            HOLD: begin
                // Two half-periods: the trailing sck-low half, then the hold itself
                if (tick) begin
                    if (!tail_q) begin
                        tail_d = 1'b1;
                    end else begin
                        state_d       = GAP;
                        cs_d          = 1'b1;
                        done_d        = 1'b1;
                        res_d.pwm_nb  = rx_q[PWM_NB_LSB +: PWM_W];
                        res_d.pwm_pb  = rx_q[PWM_PB_LSB +: PWM_W];
                        res_d.pwm_pa  = rx_q[PWM_PA_LSB +: PWM_W];
                        res_d.rundown = rx_q[RUNDOWN_LSB +: RUNDOWN_W];
                        res_d.n64     = rx_q[N64_LSB +: RES8_W];
                        res_d.p8      = rx_q[P8_LSB +: RES8_W];
                        res_d.n1      = rx_q[N1_LSB +: RES8_W];
                        res_d.err     = rx_q[ERR_LSB +: ERR_W];
                        conv_err_d    = (rx_q[ERR_LSB +: ERR_W] != '0);
                    end
                end
            end

            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                sck_d   = 1'b0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sck      = sck_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pwm_nb   = res_q.pwm_nb;
    assign pwm_pb   = res_q.pwm_pb;
    assign pwm_pa   = res_q.pwm_pa;
    assign rundown  = res_q.rundown;
    assign n64      = res_q.n64;
    assign p8       = res_q.p8;
    assign n1       = res_q.n1;
    assign err_code = res_q.err;
    assign conv_err = conv_err_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: three instances (CLKDIV 4, 2, 1) driven by a
// frame-level converter model; results compared against the sent fields.
module tb_adc_spi_reader;

    logic        clk = 1'b0;
    logic        rst_a      [3];
    logic        start_a    [3];
    logic [9:0]  nplc_a     [3];
    logic        sck_a      [3];
    logic        cs_a       [3];
    logic        mosi_a     [3];
    logic        miso_a     [3];
    logic        busy_a     [3];
    logic        done_a     [3];
    logic [31:0] pwm_nb_a   [3];
    logic [31:0] pwm_pb_a   [3];
    logic [31:0] pwm_pa_a   [3];
    logic [11:0] rundown_a  [3];
    logic [7:0]  n64_a      [3];
    logic [7:0]  p8_a       [3];
    logic [7:0]  n1_a       [3];
    logic [2:0]  err_a      [3];
    logic        conv_err_a [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adc_spi_reader #(
            .CLKDIV(g == 0 ? 4 : (g == 1 ? 2 : 1))
        ) u_dut (
            .clk     (clk),
            .rst     (rst_a[g]),
            .start   (start_a[g]),
            .nplc    (nplc_a[g]),
            .sck     (sck_a[g]),
            .cs      (cs_a[g]),
            .mosi    (mosi_a[g]),
            .miso    (miso_a[g]),
            .busy    (busy_a[g]),
            .done    (done_a[g]),
            .pwm_nb  (pwm_nb_a[g]),
            .pwm_pb  (pwm_pb_a[g]),
            .pwm_pa  (pwm_pa_a[g]),
            .rundown (rundown_a[g]),
            .n64     (n64_a[g]),
            .p8      (p8_a[g]),
            .n1      (n1_a[g]),
            .err_code(err_a[g]),
            .conv_err(conv_err_a[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic [134:0] dut_res(input int d);
        return {pwm_nb_a[d], pwm_pb_a[d], pwm_pa_a[d], rundown_a[d],
                n64_a[d], p8_a[d], n1_a[d], err_a[d]};
    endfunction

    function automatic logic [134:0] rnd_fields();
        return {$urandom, $urandom, $urandom, 12'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom)};
    endfunction

    // Converter model and bus monitor, evaluated on the falling clk edge
    int          cyc = 0;
    int          rise_cnt [3];
    int          cslow_cnt[3];
    int          hi_cnt   [3];
    int          done_cnt [3];
    int          idx_s    [3];
    int          cs_rise_cyc  [3];
    int          busy_fall_cyc[3];
    logic        prev_cs  [3];
    logic        prev_sck [3];
    logic        prev_busy[3];
    logic [135:0] sframe  [3];
    logic [135:0] mosi_cap[3];
    logic [134:0] last_res[3];
    logic [134:0] pre_done_res[3];
    logic [134:0] at_done_res [3];
    logic [134:0] model_res   [3];

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!cs_a[d]) begin
                if (prev_cs[d]) begin
                    rise_cnt[d]  = 0;
                    cslow_cnt[d] = 0;
                    hi_cnt[d]    = 0;
                    done_cnt[d]  = 0;
                    mosi_cap[d]  = '0;
                end
                cslow_cnt[d]++;
                if (sck_a[d]) hi_cnt[d]++;
                if (sck_a[d] && !prev_sck[d]) begin
                    rise_cnt[d]++;
                    mosi_cap[d] = {mosi_cap[d][134:0], mosi_a[d]};
                end
                if (!sck_a[d] && prev_sck[d]) idx_s[d]++;
            end else begin
                idx_s[d] = 0;
            end
            miso_a[d] = (!cs_a[d] && idx_s[d] < 136) ? sframe[d][135 - idx_s[d]] : 1'b0;
            if (done_a[d]) begin
                done_cnt[d]++;
                pre_done_res[d] = last_res[d];
                at_done_res[d]  = dut_res(d);
            end
            if (cs_a[d] && !prev_cs[d])     cs_rise_cyc[d]   = cyc;
            if (!busy_a[d] && prev_busy[d]) busy_fall_cyc[d] = cyc;
            last_res[d]  = dut_res(d);
            prev_cs[d]   = cs_a[d];
            prev_sck[d]  = sck_a[d];
            prev_busy[d] = busy_a[d];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rise(input int d, input int n);
        int k = 0;
        while (rise_cnt[d] < n && k < 5000) begin
            step();
            k++;
        end
        check("rise_wait", 136'(rise_cnt[d] >= n), 136'(1));
    endtask

    task automatic wait_idle(input int d);
        int k = 0;
        while (busy_a[d] && k < 5000) begin
            step();
            k++;
        end
        check("idle_wait", 136'(busy_a[d]), 136'(0));
    endtask

    task automatic do_frame(input int d, input logic [9:0] np, input logic [134:0] fld,
                            input bit inject);
        int c = div_of(d);
        logic [134:0] old = model_res[d];
        sframe[d]  = {fld, 1'($urandom)};
        nplc_a[d]  = np;
        start_a[d] = 1'b1;
        step();
        start_a[d] = 1'b0;
        nplc_a[d]  = 10'($urandom);
        if (inject) begin
            wait_rise(d, 40);
            nplc_a[d]  = ~np;
            start_a[d] = 1'b1;
            step();
            start_a[d] = 1'b0;
        end
        wait_idle(d);
        repeat (3) step();
        model_res[d] = fld;
        check("stay_idle",  136'({busy_a[d], cs_a[d], sck_a[d], mosi_a[d]}), 136'(4'b0100));
        check("mosi_frame", mosi_cap[d], {6'b0, np, 120'b0});
        check("sck_rises",  136'(rise_cnt[d]), 136'(136));
        check("sck_high",   136'(hi_cnt[d]), 136'(136 * c));
        check("cs_low",     136'(cslow_cnt[d]), 136'(274 * c));
        check("busy_tail",  136'(busy_fall_cyc[d] - cs_rise_cyc[d]), 136'(c));
        check("done_cnt",   136'(done_cnt[d]), 136'(1));
        check("pre_done",   136'(pre_done_res[d]), 136'(old));
        check("at_done",    136'(at_done_res[d]), 136'(fld));
        check("results",    136'(dut_res(d)), 136'(fld));
        check("pwm_nb",     136'(pwm_nb_a[d]), 136'(fld[134:103]));
        check("rundown",    136'(rundown_a[d]), 136'(fld[38:27]));
        check("err_code",   136'(err_a[d]), 136'(fld[2:0]));
        check("conv_err",   136'(conv_err_a[d]), 136'(fld[2:0] != 3'd0));
    endtask

    task automatic do_abort(input int d);
        sframe[d]  = {rnd_fields(), 1'b1};
        nplc_a[d]  = 10'($urandom);
        start_a[d] = 1'b1;
        step();
        start_a[d] = 1'b0;
        wait_rise(d, 70);
        rst_a[d] = 1'b0;
        step();
        check("abort_pins", 136'({cs_a[d], sck_a[d], mosi_a[d], busy_a[d], done_a[d], conv_err_a[d]}),
              136'(6'b100000));
        check("abort_res", 136'(dut_res(d)), 136'(0));
        step();
        rst_a[d] = 1'b1;
        repeat (6) step();
        check("abort_nodone", 136'({done_cnt[d], busy_a[d]}), 136'(0));
        model_res[d] = '0;
    endtask

    initial begin
        logic [134:0] fld;
        for (int d = 0; d < 3; d++) begin
            rst_a[d]     = 1'b0;
            start_a[d]   = 1'b1;
            nplc_a[d]    = 10'h3ff;
            model_res[d] = '0;
            sframe[d]    = '1;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            check("rst_pins", 136'({cs_a[d], sck_a[d], mosi_a[d], busy_a[d], done_a[d], conv_err_a[d]}),
                  136'(6'b100000));
            check("rst_res", 136'(dut_res(d)), 136'(0));
            rst_a[d]   = 1'b1;
            start_a[d] = 1'b0;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++)
            check("post_rst", 136'({cs_a[d], busy_a[d], sck_a[d]}), 136'(3'b100));

        // CLKDIV=4: directed frame, random frames, start-while-busy, abort
        fld = rnd_fields();
        fld[134:103] = 32'h12345678;
        fld[38:27]   = 12'hABC;
        fld[2:0]     = 3'd0;
        do_frame(0, 10'd100, fld, 1'b0);
        check("mosi_hdr", 136'(mosi_cap[0][135:120]), 136'(16'h0064));
        for (int i = 0; i < 2; i++) do_frame(0, 10'($urandom), rnd_fields(), 1'b0);
        do_frame(0, 10'($urandom), rnd_fields(), 1'b1);
        do_abort(0);
        do_frame(0, 10'($urandom), rnd_fields(), 1'b0);

        // CLKDIV=2: error code set then cleared, random frames
        fld = rnd_fields();
        fld[2:0] = 3'd2;
        do_frame(1, 10'($urandom), fld, 1'b0);
        fld = rnd_fields();
        fld[2:0] = 3'd0;
        do_frame(1, 10'($urandom), fld, 1'b0);
        for (int i = 0; i < 2; i++) do_frame(1, 10'($urandom), rnd_fields(), 1'b0);

        // CLKDIV=1: all-ones frame, random frames
        do_frame(2, 10'($urandom), '1, 1'b0);
        for (int i = 0; i < 2; i++) do_frame(2, 10'($urandom), rnd_fields(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
